// File: rtl/me_sched_ctrl.sv
// ---------------------------------------------------------------------------
// me_sched_ctrl
// Sequencer for the 16-lane block-matching PE array. Tracks the macroblock
// position within a frame, enables the PE array for one reference block at a
// time, and reduces the lane SADs of every result beat to the best motion
// vector. The result is presented on a valid/ready port.
//
// Ports
//   clk, rst_n    pixel clock, asynchronous active-low reset
//   vsync_start   one-cycle frame-start pulse (aborts any block in flight)
//   ref_vld       reference block load in progress (starts a search)
//   blk_ovalid    one beat of NUM_PE lane SADs valid on blk_sad
//   blk_sad       lane i SAD at [i*SAD_W +: SAD_W]
//   pe_en         PE array enable
//   mv_valid/mv_ready  result handshake
//   mv_dx, mv_dy  signed offset of best candidate, mv_sad its SAD
//   mb_x, mb_y    macroblock position of the current result
//   frame_done    one-cycle pulse after the last macroblock of a frame is taken
//   overrun       sticky: a beat arrived while a result was draining/stalled
// ---------------------------------------------------------------------------
module me_sched_ctrl #(
  parameter int NUM_PE     = 16,
  parameter int SAD_W      = 32,
  parameter int NUM_ROWS   = 16,
  parameter int MV_W       = 6,
  parameter int MB_PER_ROW = 480,
  parameter int MB_ROWS    = 270
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vsync_start,
  input  logic                    ref_vld,
  input  logic                    blk_ovalid,
  input  logic [NUM_PE*SAD_W-1:0] blk_sad,
  output logic                    pe_en,
  output logic                    mv_valid,
  input  logic                    mv_ready,
  output logic [MV_W-1:0]         mv_dx,
  output logic [MV_W-1:0]         mv_dy,
  output logic [SAD_W-1:0]        mv_sad,
  output logic [8:0]              mb_x,
  output logic [8:0]              mb_y,
  output logic                    frame_done,
  output logic                    overrun
);

  localparam int LANE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_REF,
    ST_SEARCH,
    ST_DRAIN,
    ST_OUT
  } state_t;

  state_t state, state_nxt;

  logic [ROW_W-1:0]  row_cnt;
  logic              s1_vld;
  logic [SAD_W-1:0]  s1_sad;
  logic [LANE_W-1:0] s1_lane;
  logic [ROW_W-1:0]  s1_row;
  logic [SAD_W-1:0]  best_sad;
  logic [LANE_W-1:0] best_lane;
  logic [ROW_W-1:0]  best_row;
  logic [SAD_W-1:0]  lane_min_sad;
  logic [LANE_W-1:0] lane_min_idx;

  logic beat_take, last_beat, search_start, accept, x_last, y_last, last_mb;

  assign beat_take    = (state == ST_SEARCH) && blk_ovalid;
  assign last_beat    = beat_take && (row_cnt == ROW_W'(NUM_ROWS - 1));
  assign search_start = (state == ST_WAIT_REF) && ref_vld;
  assign accept       = (state == ST_OUT) && mv_ready;
  assign x_last       = (mb_x == 9'(MB_PER_ROW - 1));
  assign y_last       = (mb_y == 9'(MB_ROWS - 1));
  assign last_mb      = x_last && y_last;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. vsync_start overrides everything and restarts the frame.
  // DRAIN leaves once stage 1 is empty, i.e. stage 2 has folded the last beat.
  always_comb begin
    state_nxt = state;
    if (vsync_start) begin
      state_nxt = ST_WAIT_REF;
    end else begin
      case (state)
        ST_IDLE:     state_nxt = ST_IDLE;
        ST_WAIT_REF: if (ref_vld) state_nxt = ST_SEARCH;
        ST_SEARCH:   if (last_beat) state_nxt = ST_DRAIN;
        ST_DRAIN:    if (!s1_vld) state_nxt = ST_OUT;
        ST_OUT:      if (mv_ready) state_nxt = last_mb ? ST_IDLE : ST_WAIT_REF;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  // Per-beat lane reduction; strict compare so the lowest lane wins ties.
  always_comb begin
    lane_min_sad = blk_sad[SAD_W-1:0];
    lane_min_idx = '0;
    for (int i = 1; i < NUM_PE; i++) begin
      if (blk_sad[i*SAD_W +: SAD_W] < lane_min_sad) begin
        lane_min_sad = blk_sad[i*SAD_W +: SAD_W];
        lane_min_idx = LANE_W'(i);
      end
    end
  end

  // Two-stage reduction pipe: stage 1 holds the beat minimum, stage 2 keeps
  // the running best. Strict compare in stage 2 lets the earlier row win ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt   <= '0;
      s1_vld    <= 1'b0;
      s1_sad    <= '0;
      s1_lane   <= '0;
      s1_row    <= '0;
      best_sad  <= '1;
      best_lane <= '0;
      best_row  <= '0;
    end else if (vsync_start) begin
      row_cnt   <= '0;
      s1_vld    <= 1'b0;
      best_sad  <= '1;
      best_lane <= '0;
      best_row  <= '0;
    end else begin
      s1_vld <= beat_take;
      if (beat_take) begin
        s1_sad  <= lane_min_sad;
        s1_lane <= lane_min_idx;
        s1_row  <= row_cnt;
      end
      if (search_start) begin
        row_cnt   <= '0;
        best_sad  <= '1;
        best_lane <= '0;
        best_row  <= '0;
      end else begin
        if (beat_take) row_cnt <= row_cnt + ROW_W'(1);
        if (s1_vld && (s1_sad < best_sad)) begin
          best_sad  <= s1_sad;
          best_lane <= s1_lane;
          best_row  <= s1_row;
        end
      end
    end
  end

  // Macroblock position, frame-done pulse and the sticky overrun flag.
  // The position advances only when a result is actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb_x       <= '0;
      mb_y       <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else if (vsync_start) begin
      mb_x       <= '0;
      mb_y       <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= accept && last_mb;
      if (blk_ovalid && ((state == ST_DRAIN) || (state == ST_OUT))) overrun <= 1'b1;
      if (accept) begin
        if (x_last) begin
          mb_x <= '0;
          mb_y <= y_last ? 9'd0 : mb_y + 9'd1;
        end else begin
          mb_x <= mb_x + 9'd1;
        end
      end
    end
  end

  // Result fields are forced to zero while no result is offered, so every
  // output reads zero out of reset even though best_sad idles at all-ones.
  assign pe_en    = (state == ST_SEARCH);
  assign mv_valid = (state == ST_OUT);
  assign mv_dx    = mv_valid ? (MV_W'(best_lane) - MV_W'(NUM_PE / 2))   : '0;
  assign mv_dy    = mv_valid ? (MV_W'(best_row)  - MV_W'(NUM_ROWS / 2)) : '0;
  assign mv_sad   = mv_valid ? best_sad : '0;

endmodule
